// File: rtl/pc_redirect_seq_if.sv
// Handshake bundle between the branch unit / fetch control and the PC
// redirect sequencer.
interface pc_redirect_seq_if;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        jmp;
  logic        branch;
  logic [31:0] offset;
  logic [31:0] target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        redirect;
  logic        redir_pend;
  logic [15:0] redir_cnt;

  modport master (
    output stall, ex_valid, ex_pc, jmp, branch, offset, target,
    input  pc, pc_valid, flush, redirect, redir_pend, redir_cnt
  );

  modport slave (
    input  stall, ex_valid, ex_pc, jmp, branch, offset, target,
    output pc, pc_valid, flush, redirect, redir_pend, redir_cnt
  );
endinterface

// File: rtl/pc_redirect_seq.sv
// Fetch PC owner: computes branch/jump targets, applies redirects,
// squashes wrong-path IF/ID slots and parks redirects seen under stall.
module pc_redirect_seq #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  pc_redirect_seq_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pc_valid_q, pc_valid_d;
  logic        redirect_q, redirect_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] redir_cnt_q, redir_cnt_d;

  logic [31:0] p4;
  logic [31:0] btgt;
  logic [31:0] jtgt;
  logic [31:0] tgt;
  logic        req;
  logic        unused_bits;

  assign p4   = bus.ex_pc + 32'd4;
  assign btgt = p4 + {{14{bus.offset[15]}}, bus.offset[15:0], 2'b00};
  assign jtgt = {p4[31:28], bus.target[25:0], 2'b00};
  assign req  = bus.ex_valid & (bus.jmp | bus.branch);
  assign tgt  = bus.jmp ? jtgt : btgt;

  assign unused_bits = ^{bus.offset[31:16], bus.target[31:26]};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    pc_valid_d  = pc_valid_q;
    redirect_d  = 1'b0;
    cnt_d       = cnt_q;
    redir_cnt_d = redir_cnt_q;

    unique case (state_q)
      BOOT: begin
        state_d    = RUN;
        pc_valid_d = 1'b1;
        pc_d       = RESET_PC;
      end
      RUN: begin
        if (req && !bus.stall) begin
          pc_d       = tgt;
          redirect_d = 1'b1;
          cnt_d      = FLUSH_INIT;
          state_d    = FLUSH;
        end else if (req) begin
          pend_d     = tgt;
          pend_vld_d = 1'b1;
          state_d    = HOLD;
        end else if (!bus.stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          pc_d       = pend_q;
          redirect_d = 1'b1;
          pend_vld_d = 1'b0;
          cnt_d      = FLUSH_INIT;
          state_d    = FLUSH;
        end
      end
      FLUSH: begin
        // EX only holds squashed slots here, so req is ignored
        if (!bus.stall) begin
          pc_d = pc_q + 32'd4;
          if (cnt_q == 4'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    if (redirect_d && redir_cnt_q != 16'hFFFF) begin
      redir_cnt_d = redir_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      pend_q      <= 32'd0;
      pend_vld_q  <= 1'b0;
      pc_valid_q  <= 1'b0;
      redirect_q  <= 1'b0;
      cnt_q       <= 4'd0;
      redir_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      pc_valid_q  <= pc_valid_d;
      redirect_q  <= redirect_d;
      cnt_q       <= cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_valid   = pc_valid_q;
  assign bus.flush      = (state_q == FLUSH);
  assign bus.redirect   = redirect_q;
  assign bus.redir_pend = pend_vld_q;
  assign bus.redir_cnt  = redir_cnt_q;

endmodule

// File: tb/tb_pc_redirect_seq.sv
// Directed bench for pc_redirect_seq: boot, branch/jump redirects,
// stall hold, stalled flush, reset abort and counter saturation.
module tb_pc_redirect_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pc_redirect_seq_if bus ();

  pc_redirect_seq #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_req();
    bus.ex_valid = 1'b0;
    bus.jmp      = 1'b0;
    bus.branch   = 1'b0;
  endtask

  task automatic br_req(input logic [31:0] epc, input logic [15:0] off);
    bus.ex_valid = 1'b1;
    bus.branch   = 1'b1;
    bus.jmp      = 1'b0;
    bus.ex_pc    = epc;
    bus.offset   = {16'h0, off};
  endtask

  task automatic jmp_req(input logic [31:0] epc, input logic [25:0] tf);
    bus.ex_valid = 1'b1;
    bus.jmp      = 1'b1;
    bus.branch   = 1'b0;
    bus.ex_pc    = epc;
    bus.target   = {6'h0, tf};
  endtask

  task automatic chk_rst(input string tag);
    check({tag, "_pc"}, bus.pc, 32'h0);
    check({tag, "_pcv"}, 32'(bus.pc_valid), 32'h0);
    check({tag, "_flush"}, 32'(bus.flush), 32'h0);
    check({tag, "_redir"}, 32'(bus.redirect), 32'h0);
    check({tag, "_pend"}, 32'(bus.redir_pend), 32'h0);
    check({tag, "_cnt"}, 32'(bus.redir_cnt), 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst        = 1'b1;
    bus.stall  = 1'b0;
    bus.ex_pc  = 32'h0;
    bus.offset = 32'h0;
    bus.target = 32'h0;
    no_req();
    tick();
    tick();
    chk_rst("rst");

    // boot and sequential fetch
    rst = 1'b0;
    check("boot_pcv", 32'(bus.pc_valid), 32'h0);
    tick();
    check("run_pcv", 32'(bus.pc_valid), 32'h1);
    check("run_pc0", bus.pc, 32'h0);
    tick();
    check("run_pc4", bus.pc, 32'h4);
    tick();
    check("run_pc8", bus.pc, 32'h8);

    // backward branch
    br_req(32'h100, 16'hFFFC);
    tick();
    no_req();
    check("br_pc", bus.pc, 32'h0F4);
    check("br_redir", 32'(bus.redirect), 32'h1);
    check("br_flush1", 32'(bus.flush), 32'h1);
    tick();
    check("br_pc2", bus.pc, 32'h0F8);
    check("br_redir_off", 32'(bus.redirect), 32'h0);
    check("br_flush2", 32'(bus.flush), 32'h1);
    tick();
    check("br_flush_end", 32'(bus.flush), 32'h0);
    check("br_pc3", bus.pc, 32'h0FC);
    check("br_cnt", 32'(bus.redir_cnt), 32'h1);

    // jump, then jump+branch where jump wins
    jmp_req(32'h3000_0010, 26'h0000040);
    tick();
    no_req();
    check("j_pc", bus.pc, 32'h3000_0100);
    check("j_redir", 32'(bus.redirect), 32'h1);
    tick();
    tick();
    check("j_pc_after", bus.pc, 32'h3000_0108);
    jmp_req(32'h3000_0010, 26'h0000040);
    bus.branch = 1'b1;
    bus.offset = 32'h0000_FFFC;
    tick();
    no_req();
    check("jb_pc", bus.pc, 32'h3000_0100);
    tick();
    tick();
    check("jb_cnt", 32'(bus.redir_cnt), 32'h3);
    check("jb_pc_after", bus.pc, 32'h3000_0108);

    // redirect arriving under stall
    bus.stall = 1'b1;
    br_req(32'h1FC, 16'h0000);
    tick();
    no_req();
    check("h_pend", 32'(bus.redir_pend), 32'h1);
    check("h_pc", bus.pc, 32'h3000_0108);
    check("h_redir", 32'(bus.redirect), 32'h0);
    jmp_req(32'h0, 26'h0000123);
    tick();
    no_req();
    tick();
    check("h_pc_frozen", bus.pc, 32'h3000_0108);
    check("h_pend2", 32'(bus.redir_pend), 32'h1);
    bus.stall = 1'b0;
    tick();
    check("h_pc_tgt", bus.pc, 32'h200);
    check("h_redir_go", 32'(bus.redirect), 32'h1);
    check("h_pend_clr", 32'(bus.redir_pend), 32'h0);
    check("h_flush", 32'(bus.flush), 32'h1);
    tick();
    tick();
    check("h_flush_end", 32'(bus.flush), 32'h0);
    check("h_pc_end", bus.pc, 32'h208);

    // stall in the middle of a flush, req ignored
    br_req(32'h100, 16'h0010);
    tick();
    no_req();
    check("f_pc", bus.pc, 32'h144);
    bus.stall = 1'b1;
    jmp_req(32'h0, 26'h0000400);
    tick();
    check("f_st_flush", 32'(bus.flush), 32'h1);
    check("f_st_pc", bus.pc, 32'h144);
    tick();
    check("f_st_flush2", 32'(bus.flush), 32'h1);
    bus.stall = 1'b0;
    tick();
    check("f_flush2", 32'(bus.flush), 32'h1);
    check("f_pc2", bus.pc, 32'h148);
    tick();
    no_req();
    check("f_flush_end", 32'(bus.flush), 32'h0);
    check("f_pc3", bus.pc, 32'h14C);
    check("f_no_redir", 32'(bus.redirect), 32'h0);
    check("f_cnt", 32'(bus.redir_cnt), 32'h5);

    // reset during flush
    br_req(32'h100, 16'h0010);
    tick();
    no_req();
    rst = 1'b1;
    tick();
    chk_rst("rf");
    rst = 1'b0;
    tick();
    check("rf_pc", bus.pc, 32'h0);

    // reset during hold discards the parked target
    bus.stall = 1'b1;
    br_req(32'h1FC, 16'h0000);
    tick();
    no_req();
    check("rh_pend", 32'(bus.redir_pend), 32'h1);
    rst = 1'b1;
    tick();
    chk_rst("rh");
    rst       = 1'b0;
    bus.stall = 1'b0;
    tick();
    tick();
    check("rh_pc", bus.pc, 32'h4);
    check("rh_redir", 32'(bus.redirect), 32'h0);

    // saturation, starting near the top of the counter range
    dut.redir_cnt_q = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      br_req(32'h100, 16'h0000);
      tick();
      no_req();
      check("sat_redir", 32'(bus.redirect), 32'h1);
      tick();
      tick();
      check("sat_cnt", 32'(bus.redir_cnt), (i == 0) ? 32'hFFFE : 32'hFFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
